// File: rtl/mem_bank_group.sv
// mem_bank_group: NUM_BANK independent byte-masked single-port banks with a
// zero-fill clear sequencer. Define MEM_BG_OUT_REG_EN for an extra output stage.
module mem_bank_group #(
  parameter  int NUM_BANK = 8,
  parameter  int DEPTH    = 128,
  parameter  int WIDTH    = 256,
  localparam int AW       = $clog2(DEPTH),
  localparam int BW       = WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_BANK-1:0]       req,
  input  logic [NUM_BANK-1:0]       we,
  input  logic [NUM_BANK*AW-1:0]    addr,
  input  logic [NUM_BANK*WIDTH-1:0] wdata,
  input  logic [NUM_BANK*BW-1:0]    wmask,
  output logic [NUM_BANK*WIDTH-1:0] rdata,
  output logic [NUM_BANK-1:0]       rvalid,
  output logic                      ready,
  input  logic                      clr_start,
  output logic                      clr_busy
);

  typedef enum logic {
    S_CLEAR,
    S_RUN
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [AW-1:0] r_clr_cnt;
  logic [AW-1:0] w_clr_cnt_nx;

  assign ready    = (r_state == S_RUN);
  assign clr_busy = (r_state == S_CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_clr_cnt <= w_clr_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_clr_cnt_nx = r_clr_cnt;
    case (r_state)
      S_CLEAR: begin
        if (r_clr_cnt == AW'(DEPTH - 1)) begin
          w_state_nx   = S_RUN;
          w_clr_cnt_nx = '0;
        end else begin
          w_clr_cnt_nx = r_clr_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (clr_start) w_state_nx = S_CLEAR;
      end
      default: w_state_nx = S_CLEAR;
    endcase
  end

  for (genvar g = 0; g < NUM_BANK; g++) begin : g_bank
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    w_a;
    logic             w_inr;
    logic             w_wr;
    logic             w_rd;
    logic             r_s1_vld;
    logic [WIDTH-1:0] r_s1_dat;
    logic             r_s2_vld;
    logic [WIDTH-1:0] r_s2_dat;

    assign w_a   = addr[g*AW +: AW];
    assign w_inr = ({1'b0, w_a} < (AW+1)'(DEPTH));
    assign w_wr  = ready & req[g] & we[g] & w_inr;
    assign w_rd  = ready & req[g] & ~we[g];

    // Array has no reset; the clear sequencer owns initialisation.
    always_ff @(posedge clk) begin
      if (r_state == S_CLEAR) begin
        r_mem[r_clr_cnt] <= '0;
      end else if (w_wr) begin
        for (int k = 0; k < BW; k++) begin
          if (wmask[g*BW+k])
            r_mem[w_a][8*k +: 8] <= wdata[g*WIDTH+8*k +: 8];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1_vld <= 1'b0;
        r_s1_dat <= '0;
        r_s2_vld <= 1'b0;
        r_s2_dat <= '0;
      end else begin
        r_s1_vld <= w_rd;
        if (w_rd) r_s1_dat <= w_inr ? r_mem[w_a] : '0;
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) r_s2_dat <= r_s1_dat;
      end
    end

`ifdef MEM_BG_OUT_REG_EN
    logic             r_s3_vld;
    logic [WIDTH-1:0] r_s3_dat;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s3_vld <= 1'b0;
        r_s3_dat <= '0;
      end else begin
        r_s3_vld <= r_s2_vld;
        if (r_s2_vld) r_s3_dat <= r_s2_dat;
      end
    end

    assign rvalid[g]              = r_s3_vld;
    assign rdata[g*WIDTH +: WIDTH] = r_s3_dat;
`else
    assign rvalid[g]              = r_s2_vld;
    assign rdata[g*WIDTH +: WIDTH] = r_s2_dat;
`endif
  end

endmodule

// File: tb/tb_mem_bank_group.sv
// tb_mem_bank_group: random traffic against an array/queue reference model,
// with directed masked-write, out-of-range, clear and mid-clear reset cases.
module tb_mem_bank_group;

  localparam int NB  = 8;
  localparam int DEP = 100;
  localparam int WD  = 64;
  localparam int AW  = $clog2(DEP);
  localparam int BW  = WD / 8;
  localparam int TW  = NB * WD;
`ifdef MEM_BG_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NB-1:0] req = '0;
  logic [NB-1:0] we = '0;
  logic [NB*AW-1:0] addr = '0;
  logic [TW-1:0] wdata = '0;
  logic [NB*BW-1:0] wmask = '0;
  logic [TW-1:0] rdata;
  logic [NB-1:0] rvalid;
  logic          ready;
  logic          clr_start = 1'b0;
  logic          clr_busy;

  mem_bank_group #(
    .NUM_BANK(NB),
    .DEPTH   (DEP),
    .WIDTH   (WD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .wmask    (wmask),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .ready    (ready),
    .clr_start(clr_start),
    .clr_busy (clr_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          bank;
    logic [WD-1:0] data;
  } rsp_t;

  logic [WD-1:0] m_mem [NB][DEP];
  logic [WD-1:0] m_last [NB];
  rsp_t          q[$];
  int            m_clr_left;
  int            cyc = 0;
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic chk(input string tag, input logic [TW-1:0] got,
                     input logic [TW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
  endtask

  task automatic model_reset();
    m_clr_left = DEP;
    q.delete();
    for (int b = 0; b < NB; b++) begin
      m_last[b] = '0;
      for (int a = 0; a < DEP; a++) m_mem[b][a] = '0;
    end
  endtask

  task automatic model_edge();
    bit rdy;
    rdy = (m_clr_left == 0);
    for (int b = 0; b < NB; b++) begin
      if (rdy && req[b]) begin
        int a;
        a = int'(addr[b*AW +: AW]);
        if (we[b]) begin
          if (a < DEP)
            for (int k = 0; k < BW; k++)
              if (wmask[b*BW+k])
                m_mem[b][a][8*k +: 8] = wdata[b*WD+8*k +: 8];
        end else begin
          rsp_t r;
          r.due  = cyc + 1 + LAT;
          r.bank = b;
          if (a < DEP) r.data = m_mem[b][a];
          else r.data = '0;
          q.push_back(r);
        end
      end
    end
    if (rdy && clr_start) begin
      m_clr_left = DEP;
      for (int b = 0; b < NB; b++)
        for (int a = 0; a < DEP; a++) m_mem[b][a] = '0;
    end else if (!rdy) begin
      m_clr_left--;
    end
  endtask

  task automatic check_outputs();
    logic [NB-1:0] ev;
    logic [TW-1:0] ed;
    ev = '0;
    while (q.size() > 0 && q[0].due == cyc) begin
      rsp_t r;
      r = q.pop_front();
      ev[r.bank] = 1'b1;
      m_last[r.bank] = r.data;
    end
    for (int b = 0; b < NB; b++) ed[b*WD +: WD] = m_last[b];
    chk("rvalid", TW'(rvalid), TW'(ev));
    chk("rdata", rdata, ed);
    chk("ready", TW'(ready), TW'(m_clr_left == 0));
    chk("clr_busy", TW'(clr_busy), TW'(m_clr_left != 0));
  endtask

  task automatic cycle();
    if (rst_n) model_edge();
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic idle();
    req       = '0;
    we        = '0;
    clr_start = 1'b0;
  endtask

  task automatic op(input int b, input bit w, input int a,
                    input logic [WD-1:0] d, input logic [BW-1:0] m);
    req[b]              = 1'b1;
    we[b]               = w;
    addr[b*AW +: AW]    = AW'(a);
    wdata[b*WD +: WD]   = d;
    wmask[b*BW +: BW]   = m;
  endtask

  task automatic drive_rand(input int clr_odds);
    req = NB'($urandom);
    we  = NB'($urandom);
    for (int b = 0; b < NB; b++) begin
      if ($urandom_range(0, 3) == 0) addr[b*AW +: AW] = AW'($urandom);
      else addr[b*AW +: AW] = AW'($urandom_range(0, 15));
    end
    for (int j = 0; j < TW / 32; j++) wdata[32*j +: 32] = $urandom;
    wmask = {$urandom, $urandom};
    clr_start = (clr_odds > 0) && ($urandom_range(1, clr_odds) == 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    repeat (2) cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #3;
    idle();
    do_reset();
    // Random requests during the initial clear must all be ignored.
    repeat (DEP) begin
      drive_rand(4);
      cycle();
    end
    idle();
    repeat (2) cycle();

    op(0, 1'b1, 5, {BW{8'hA5}}, {BW{1'b1}});
    cycle();
    idle();
    op(0, 1'b1, 5, {BW{8'hFF}}, BW'(1));
    cycle();
    idle();
    op(0, 1'b0, 5, '0, '0);
    op(3, 1'b0, 'h7F, '0, '0);
    cycle();
    idle();
    repeat (LAT) cycle();
    chk("mask_b0", TW'(rdata[WD-1:0]), TW'({{(BW-1){8'hA5}}, 8'hFF}));
    chk("oor_b3_v", TW'(rvalid[3]), TW'(1));
    chk("oor_b3_d", TW'(rdata[3*WD +: WD]), TW'(0));

    op(2, 1'b1, 110, 64'hDEAD_BEEF_0123_4567, {BW{1'b1}});
    cycle();
    idle();
    op(2, 1'b0, 110, '0, '0);
    cycle();
    idle();
    repeat (LAT + 1) cycle();

    repeat (1500) begin
      drive_rand(200);
      cycle();
    end
    idle();
    repeat (DEP + 4) cycle();

    op(0, 1'b1, 7, 64'h1111_2222_3333_4444, {BW{1'b1}});
    cycle();
    idle();
    op(0, 1'b0, 7, '0, '0);
    clr_start = 1'b1;
    cycle();
    idle();
    repeat (DEP + 2) cycle();
    op(0, 1'b0, 7, '0, '0);
    cycle();
    idle();
    repeat (LAT + 1) cycle();

    clr_start = 1'b1;
    cycle();
    idle();
    repeat (60) begin
      drive_rand(0);
      cycle();
    end
    idle();
    do_reset();
    repeat (DEP + 2) begin
      drive_rand(0);
      cycle();
    end
    repeat (300) begin
      drive_rand(150);
      cycle();
    end
    idle();
    repeat (LAT + 2) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_bank_group.md
# mem_bank_group

Parametrised bank-group memory: `NUM_BANK` independent single-port banks, each `DEPTH` x `WIDTH`, with one request channel per bank. It replaces the fixed 8-bank 128x256 groups in the bank subsystem. Over a fixed group it adds:

- byte-masked writes;
- a registered read-valid pipeline;
- a hardware clear sequencer that zero-fills every bank after reset or on command.

It sits between the bank-group address router and the compute datapath.

## Interface

Parameters:

- `NUM_BANK`, default 8: number of banks/channels (≥1).
- `DEPTH`, default 128: words per bank (≥2; need not be a power of two).
- `WIDTH`, default 256: word width in bits; must be a multiple of 8.
- `AW` (localparam): `$clog2(DEPTH)`.

Ports:

- `clk` in, 1: sole clock; all logic rising-edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `req` in, `NUM_BANK`: per-bank request strobe, active-high.
- `we` in, `NUM_BANK`: per-bank write select (1 = write, 0 = read); sampled with `req`.
- `addr` in, `NUM_BANK*AW`: packed word addresses; bank i uses `[i*AW +: AW]`.
- `wdata` in, `NUM_BANK*WIDTH`: packed write data.
- `wmask` in, `NUM_BANK*WIDTH/8`: packed byte enables; 1 = byte written.
- `rdata` out, `NUM_BANK*WIDTH`: packed read data.
- `rvalid` out, `NUM_BANK`: per-bank read-data-valid pulse.
- `ready` out, 1: high when requests are accepted (state RUN).
- `clr_start` in, 1: single-cycle pulse requesting a zero-fill of all banks.
- `clr_busy` out, 1: high while the clear sequence runs.

## Operation

State machine (`state`, `clr_cnt[AW-1:0]`):

- **CLEAR**
  - Each cycle writes all-zero, full mask, at `clr_cnt` in every bank, then increments `clr_cnt`.
  - When `clr_cnt == DEPTH-1` is written, go to RUN and zero `clr_cnt`.
  - `ready = 0`, `clr_busy = 1`.
- **RUN**
  - Per bank, `req[i] & ready` is accepted.
  - Write: byte k of `mem[addr]` takes `wdata` byte k where `wmask` bit k = 1; other bytes are kept.
  - Read: schedules `rdata`/`rvalid` for bank i.
  - `clr_start` in RUN moves to CLEAR on the next edge.

Rules:

- Reset (assert at any time, including mid-clear) → CLEAR with `clr_cnt = 0`. The clear restarts from address 0.
- `req` while `ready = 0` is ignored: no write, no `rvalid`.
- `clr_start` during CLEAR is ignored; the counter is not restarted.
- A request in the same cycle as `clr_start` in RUN is accepted. Its `rvalid` is still delivered, even though the response arrives during CLEAR.
- Address ≥ `DEPTH`: the write is dropped; the read returns `rvalid = 1` with all-zero data.
- A write never produces `rvalid`. A read returns the contents before any write in that cycle; only one op per bank per cycle exists.
- Banks are fully independent; there is no cross-bank arbitration.
- `rdata[i]` holds its last value between reads.

## Timing

- Reset values:
  - `rdata` = 0, `rvalid` = 0.
  - `ready` = 0, `clr_busy` = 1.
  - `state` = CLEAR.
  - Array contents are undefined until the clear completes.
- Clear duration: exactly `DEPTH` cycles. `ready` rises in the cycle after the last clear write, i.e. `DEPTH` cycles after reset release (128 at default).
- Read latency: 1 cycle. A request accepted at edge N gives `rdata`/`rvalid` valid after edge N+1.
- `rvalid` is a one-cycle pulse per accepted read. Back-to-back reads give continuous `rvalid`.
- Write latency: data is visible to a read accepted at the next edge.

## Configuration

- `MEM_BG_OUT_REG_EN` defined:
  - Adds a second output register stage on `rdata`/`rvalid` (reset to 0).
  - Read latency becomes 2 cycles.
  - Reads in flight at `clr_start` are still delivered.
- Undefined: single-stage output, read latency 1.

## Test plan

- Reset release, no traffic → `ready` low for 128 cycles, then high. A read of bank 3, addr 0x7F returns `rvalid` with `rdata` = 0.
- Write bank 0 addr 5, `wdata` = all 0xA5 bytes, `wmask` = all-ones. Then write `wdata` = all 0xFF with `wmask` = 0x0000_0001. Then read → byte 0 = 0xFF, bytes 1..31 = 0xA5, at latency 1 (2 with macro).
- All 8 banks read different addresses in the same cycle for 4 consecutive cycles → 4 continuous `rvalid` = 0xFF cycles, each bank's data matching its prior writes.
- `clr_start` pulsed alongside a read in RUN → the read's `rvalid` is delivered. `ready` is low for 128 cycles, then all previously written words read 0.
- `rst_n` asserted at clear cycle 60 and released → the full 128-cycle clear restarts. `ready` stays low 128 cycles after release.
- `DEPTH` = 100 build: a write to addr 110 is dropped, and a read of 110 returns `rvalid` = 1 with zero data. A `req` issued during CLEAR produces no `rvalid`.
